// File: rtl/if_id_stage_control_pkg.sv
// Shared front-end pipeline definitions: stage-state encoding, NOP encoding and default datapath width.
package if_id_stage_control_pkg;

    localparam int unsigned IFID_DATA_W = 32;

    // sll $0,$0,0
    localparam logic [31:0] IFID_NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } stage_state_e;

endpackage

// File: rtl/if_id_stage_control_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; stops at all-ones.
module if_id_stage_control_sat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/if_id_stage_control.sv
// IF/ID register and front-end stall/flush control for the 5-stage MIPS pipeline.
// Optional StallCount/FlushCount outputs when IF_ID_PERF_COUNTERS_EN is defined.
//
// state  | meaning
// RUN    | last edge loaded a fresh fetch into IF/ID
// HOLD   | last edge held IF/ID because of a load-use stall
// SQUASH | last edge replaced IF/ID with a NOP bubble (taken branch)
module if_id_stage_control
    import if_id_stage_control_pkg::*;
#(
    parameter int                DATA_W    = IFID_DATA_W,
    parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(IFID_NOP_WORD),
    parameter int                MAX_STALL = 4,
    parameter int                CNT_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [DATA_W-1:0] PC_Plus4_in,
    input  logic [DATA_W-1:0] Instruction_in,
    output logic              PCWrite,
    output logic [DATA_W-1:0] IF_ID_PC_Plus4,
    output logic [DATA_W-1:0] IF_ID_Instruction,
    output logic              IF_ID_Valid,
    output logic              ID_EX_Bubble,
    output logic [1:0]        StageState,
    output logic              StallTimeout
`ifdef IF_ID_PERF_COUNTERS_EN
    ,
    output logic [31:0]       StallCount,
    output logic [31:0]       FlushCount
`endif
);

    stage_state_e stateQ, stateD;
    logic [CNT_W-1:0] stallCnt;
    logic doFlush;

    // Stall wins: the branch was resolved on stale operands, so it is re-evaluated next cycle.
    assign doFlush = Flush & ~Stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= RUN;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD       = RUN;
        PCWrite      = 1'b1;
        ID_EX_Bubble = 1'b0;
        if (!reset) begin
            PCWrite      = ~Stall;
            ID_EX_Bubble = Stall;
            if (Stall) begin
                stateD = HOLD;
            end else if (Flush) begin
                stateD = SQUASH;
            end
        end
    end

    assign StageState = stateQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            IF_ID_PC_Plus4    <= '0;
            IF_ID_Instruction <= NOP_WORD;
            IF_ID_Valid       <= 1'b0;
        end else if (!Stall) begin
            IF_ID_PC_Plus4    <= PC_Plus4_in;
            IF_ID_Instruction <= doFlush ? NOP_WORD : Instruction_in;
            IF_ID_Valid       <= ~doFlush;
        end
    end

    if_id_stage_control_sat_counter #(.W(CNT_W)) uStallCnt (
        .clk   (clk),
        .reset (reset),
        .clear (~Stall),
        .en    (Stall),
        .count (stallCnt)
    );

    // The edge that takes the counter from MAX_STALL to MAX_STALL+1 raises the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            StallTimeout <= 1'b0;
        end else if (Stall && (stallCnt == CNT_W'(MAX_STALL))) begin
            StallTimeout <= 1'b1;
        end
    end

`ifdef IF_ID_PERF_COUNTERS_EN
    if_id_stage_control_sat_counter #(.W(32)) uStallPerf (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .en    (Stall),
        .count (StallCount)
    );

    if_id_stage_control_sat_counter #(.W(32)) uFlushPerf (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .en    (doFlush),
        .count (FlushCount)
    );
`endif

endmodule

// File: tb/tb_if_id_stage_control.sv
// Directed self-checking bench for if_id_stage_control; perf-counter checks follow IF_ID_PERF_COUNTERS_EN.
module tb_if_id_stage_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Flush;
    logic [31:0] PC_Plus4_in;
    logic [31:0] Instruction_in;
    logic        PCWrite;
    logic [31:0] IF_ID_PC_Plus4;
    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_Valid;
    logic        ID_EX_Bubble;
    logic [1:0]  StageState;
    logic        StallTimeout;
`ifdef IF_ID_PERF_COUNTERS_EN
    logic [31:0] StallCount;
    logic [31:0] FlushCount;
`endif

    int nChecks = 0;
    int nErrors = 0;

    if_id_stage_control dut (
        .clk               (clk),
        .reset             (reset),
        .Stall             (Stall),
        .Flush             (Flush),
        .PC_Plus4_in       (PC_Plus4_in),
        .Instruction_in    (Instruction_in),
        .PCWrite           (PCWrite),
        .IF_ID_PC_Plus4    (IF_ID_PC_Plus4),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_Valid       (IF_ID_Valid),
        .ID_EX_Bubble      (ID_EX_Bubble),
        .StageState        (StageState),
        .StallTimeout      (StallTimeout)
`ifdef IF_ID_PERF_COUNTERS_EN
        ,
        .StallCount        (StallCount),
        .FlushCount        (FlushCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks every IF/ID-visible output against the expected set.
    task automatic checkRegs(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic vld, input logic [1:0] st);
        nChecks++;
        if (IF_ID_PC_Plus4 !== pc) begin
            nErrors++;
            $display("FAIL %s_pc got=%h exp=%h", tag, IF_ID_PC_Plus4, pc);
        end
        nChecks++;
        if (IF_ID_Instruction !== ins) begin
            nErrors++;
            $display("FAIL %s_instr got=%h exp=%h", tag, IF_ID_Instruction, ins);
        end
        nChecks++;
        if (IF_ID_Valid !== vld) begin
            nErrors++;
            $display("FAIL %s_valid got=%b exp=%b", tag, IF_ID_Valid, vld);
        end
        nChecks++;
        if (StageState !== st) begin
            nErrors++;
            $display("FAIL %s_state got=%0d exp=%0d", tag, StageState, st);
        end
    endtask

    task automatic checkComb(input string tag, input logic pcw, input logic bub);
        nChecks++;
        if (PCWrite !== pcw) begin
            nErrors++;
            $display("FAIL %s_pcwrite got=%b exp=%b", tag, PCWrite, pcw);
        end
        nChecks++;
        if (ID_EX_Bubble !== bub) begin
            nErrors++;
            $display("FAIL %s_bubble got=%b exp=%b", tag, ID_EX_Bubble, bub);
        end
    endtask

    task automatic checkTimeout(input string tag, input logic exp);
        nChecks++;
        if (StallTimeout !== exp) begin
            nErrors++;
            $display("FAIL %s_timeout got=%b exp=%b", tag, StallTimeout, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; Stall = 1'b1; Flush = 1'b1;
        PC_Plus4_in = 32'h44; Instruction_in = 32'h8C08_0004;
        #1;
        checkComb("reset_comb", 1'b1, 1'b0);
        tick(); tick();
        checkRegs("reset", 32'h0, 32'h0, 1'b0, 2'd0);
        checkComb("reset_comb2", 1'b1, 1'b0);
        checkTimeout("reset", 1'b0);
`ifdef IF_ID_PERF_COUNTERS_EN
        nChecks++;
        if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin
            nErrors++;
            $display("FAIL reset_perf got=%0d/%0d exp=0/0", StallCount, FlushCount);
        end
`endif
        Stall = 1'b0; Flush = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        PC_Plus4_in = 32'h04; Instruction_in = 32'h2009_0001;
        #1;
        checkComb("run_comb", 1'b1, 1'b0);
        tick();
        checkRegs("run", 32'h04, 32'h2009_0001, 1'b1, 2'd0);
    endtask

    task automatic test_stall();
        PC_Plus4_in = 32'h08; Instruction_in = 32'h0128_5020; Stall = 1'b1;
        #1;
        checkComb("stall_comb", 1'b0, 1'b1);
        tick();
        checkRegs("stall_hold", 32'h04, 32'h2009_0001, 1'b1, 2'd1);
        Stall = 1'b0;
        #1;
        checkComb("stall_release", 1'b1, 1'b0);
        tick();
        checkRegs("stall_after", 32'h08, 32'h0128_5020, 1'b1, 2'd0);
    endtask

    task automatic test_flush();
        PC_Plus4_in = 32'h10; Instruction_in = 32'h1000_FFFF; Flush = 1'b1;
        #1;
        checkComb("flush_comb", 1'b1, 1'b0);
        tick();
        checkRegs("flush", 32'h10, 32'h0, 1'b0, 2'd2);
        Flush = 1'b0;
    endtask

    task automatic test_stall_over_flush();
        PC_Plus4_in = 32'h14; Instruction_in = 32'hAC08_0008;
        Stall = 1'b1; Flush = 1'b1;
        #1;
        checkComb("sf_comb", 1'b0, 1'b1);
        tick();
        checkRegs("sf_hold", 32'h10, 32'h0, 1'b0, 2'd1);
`ifdef IF_ID_PERF_COUNTERS_EN
        nChecks++;
        if (FlushCount !== 32'd1) begin
            nErrors++;
            $display("FAIL sf_flushcount got=%0d exp=1", FlushCount);
        end
`endif
        Stall = 1'b0;   // HOLD -> SQUASH with Flush still high
        tick();
        checkRegs("sf_squash", 32'h14, 32'h0, 1'b0, 2'd2);
        Flush = 1'b0; PC_Plus4_in = 32'h18; Instruction_in = 32'h0000_0020;
        tick();
        checkRegs("sf_run", 32'h18, 32'h0000_0020, 1'b1, 2'd0);
    endtask

    task automatic test_timeout();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        PC_Plus4_in = 32'h20; Instruction_in = 32'h2108_0001;
        tick();
        Stall = 1'b1; PC_Plus4_in = 32'h24; Instruction_in = 32'h2108_0002;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkTimeout($sformatf("to_edge%0d", i), 1'b0);
        end
        tick();
        checkTimeout("to_edge5", 1'b1);
        checkRegs("to_hold", 32'h20, 32'h2108_0001, 1'b1, 2'd1);
`ifdef IF_ID_PERF_COUNTERS_EN
        nChecks++;
        if (StallCount !== 32'd5) begin
            nErrors++;
            $display("FAIL to_stallcount got=%0d exp=5", StallCount);
        end
`endif
        Stall = 1'b0;
        tick(); tick();
        checkTimeout("to_sticky", 1'b1);
        checkRegs("to_run", 32'h24, 32'h2108_0002, 1'b1, 2'd0);
        reset = 1'b1;
        tick();
        checkTimeout("to_cleared", 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        PC_Plus4_in = 32'h30; Instruction_in = 32'h8D09_0000;
        tick();
        Stall = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        checkRegs("rms", 32'h0, 32'h0, 1'b0, 2'd0);
        checkTimeout("rms", 1'b0);
        reset = 1'b0;
        // Counter must restart from zero: four more stalled edges stay below the limit.
        for (int i = 1; i <= 4; i++) tick();
        checkTimeout("rms_edge4", 1'b0);
        tick();
        checkTimeout("rms_edge5", 1'b1);
        Stall = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        PC_Plus4_in = '0; Instruction_in = '0;
        test_reset();
        test_free_run();
        test_stall();
        test_flush();
        test_stall_over_flush();
        test_timeout();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
